alu_ctrl_seq: RTL and testbench
===============================

# alu_ctrl_seq

Sequencing controller that drives the `alu_module` datapath ALU. It accepts one 32-bit data-processing instruction at a time over a valid/ready handshake and reads operands from an internal 16×32 register file. It presents A/B/OP/cmd to the ALU, then commits the result and the NZCV status register subject to the instruction's condition field. It is the issuing side of the ALU interface: it produces `cmd`/operands and consumes `out`/`flags`.

## Interface
- `RF_DEPTH`, 16: register-file entries; fixed, addressed by 4-bit fields.
- `clk` input 1: sole clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `instr_valid` input 1: instruction offered.
- `instr_ready` output 1: high only in IDLE.
- `instr` input 32: `[31:28]` cond, `[27:26]` op, `[25]` I, `[24:21]` cmd, `[20]` S, `[19:16]` Rn, `[15:12]` Rd, `[11:0]` src2.
- `alu_a`, `alu_b` output 32: ALU operands.
- `alu_op` output 2: copy of `instr[27:26]`.
- `alu_cmd` output 4: copy of `instr[24:21]`.
- `alu_out` input 32: ALU result.
- `alu_flags` input 4: ALU `{N,Z,C,V}`.
- `wb_en` output 1: one-cycle register-write strobe.
- `wb_addr` output 4, `wb_data` output 32: write target and value.
- `nzcv` output 4: architectural status register.
- `done` output 1: one-cycle pulse when an instruction retires, whether executed or skipped.
- `illegal` output 1: one-cycle pulse, coincident with `done`, for an unsupported encoding.

## Operation
- States: IDLE → READ → EXEC → WB → IDLE. There are no other transitions, except that `rst` forces IDLE from any state.
- IDLE: `instr_ready=1`. On `instr_valid && instr_ready`, latch `instr` and go to READ. `instr_valid` is ignored in all other states.
- READ: read `rf[Rn]` into the A operand register.
  - I=0: B = `rf[src2[3:0]]`. `src2[11:4]` is ignored.
  - I=1: B = immediate (see Configuration).
  - Evaluate the condition against the current `nzcv`: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL; 15 never.
- EXEC: drive `alu_a/alu_b/alu_op/alu_cmd` from the latched values and capture `alu_out` and `alu_flags` into internal registers at the end of the cycle. The ALU outputs remain driven with these values throughout READ, EXEC and WB; they are 0 in IDLE.
- WB: pulse `done`.
  - Legal encodings are op=00 with cmd ∈ {0 AND, 1 XOR, 2 SUB, 3 RSB, 4 ADD, 10 CMP, 12 OR}. Anything else pulses `illegal` and performs no writes.
  - When the condition passes and the encoding is legal:
    - A cmd other than CMP writes the result: `wb_en=1`, `wb_addr=Rd`, `wb_data=result`, and `rf[Rd]` is updated.
    - `nzcv` ← captured flags when S=1 or cmd=CMP.
  - When the condition fails: no writes.
- R15 is an ordinary register; there is no PC semantics.
- Register file reads in READ observe all prior writebacks. No forwarding is needed because only one instruction is in flight.

## Timing
- Handshake accepted at edge T. READ occupies T+1, EXEC T+2, WB T+3. `wb_en`, `done` and `illegal` are high during cycle T+3 only. `rf` and `nzcv` are updated at the end of T+3.
- `instr_ready` returns high in cycle T+4. Throughput is one instruction per 4 cycles.
- Reset values: state IDLE, `instr_ready=1`; `nzcv`, all `rf` entries, `alu_*`, `wb_*`, `done` and `illegal` all 0.
- `rst` asserted mid-instruction abandons it. No writeback or `done` occurs for it, and the next cycle is IDLE with reset values.
- `rst` and `instr_valid` high in the same cycle: the instruction is not accepted.

## Configuration
- `ALU_CTRL_IMM_ROT_EN` defined: the I=1 immediate is `src2[7:0]` zero-extended and rotated right by `2*src2[11:8]` (32-bit rotate).
- Undefined: the immediate is `src2[7:0]` zero-extended. `src2[11:8]` is ignored.

## Test plan
- Reset, then ADD AL, S=0, Rn=r0, I=1, imm 5, Rd=r1 → at T+3: `wb_en=1`, `wb_addr=1`, `wb_data=5`, `done=1`; `nzcv` stays 0000.
- With r1=5, CMP AL, Rn=r1, I=1, imm 5 → no `wb_en`; `nzcv` Z=1. A following ADD EQ to r2 writes; ADD NE to r3 produces `done` with `wb_en=0`.
- SUB with S=1, r1=5, imm 6 → `wb_data=0xFFFFFFFF`; `nzcv` N=1, Z=0.
- Illegal encodings cmd=7, and op=01 with cmd=4 → `illegal` and `done` pulse; `rf` and `nzcv` unchanged.
- With the macro defined, I=1, `src2=0x1FF` → B=0xC000003F. With the macro undefined → B=0x000000FF.
- Assert `rst` during EXEC → no `wb_en` or `done`. The next cycle has `instr_ready=1` and all outputs at reset values.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: issue-side sequencer for the datapath ALU.
// Accepts one data-processing instruction at a time (valid/ready), reads
// operands from a 16x32 register file, drives the ALU for one cycle, then
// retires the instruction with conditional writeback and NZCV update.
// Flow per instruction: IDLE -> READ -> EXEC -> WB -> IDLE (4 cycles).
// Optional feature macro: ALU_CTRL_IMM_ROT_EN
//   defined   : I=1 immediate is imm8 rotated right by 2*rot4
//   undefined : I=1 immediate is imm8 zero-extended
module alu_ctrl_seq #(
    parameter int RF_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_op,
    output logic [3:0]  alu_cmd,
    input  logic [31:0] alu_out,
    input  logic [3:0]  alu_flags,
    output logic        wb_en,
    output logic [3:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [3:0]  nzcv,
    output logic        done,
    output logic        illegal
);

    // ALU command codes this controller knows how to retire.
    localparam logic [3:0] CMD_AND = 4'd0;
    localparam logic [3:0] CMD_XOR = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_RSB = 4'd3;
    localparam logic [3:0] CMD_ADD = 4'd4;
    localparam logic [3:0] CMD_CMP = 4'd10;
    localparam logic [3:0] CMD_OR  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    // Condition-code evaluation against {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n;
        logic z;
        logic c;
        logic v;
        logic ok;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'd0:    ok = z;
            4'd1:    ok = ~z;
            4'd2:    ok = c;
            4'd3:    ok = ~c;
            4'd4:    ok = n;
            4'd5:    ok = ~n;
            4'd6:    ok = v;
            4'd7:    ok = ~v;
            4'd8:    ok = c & ~z;
            4'd9:    ok = ~c | z;
            4'd10:   ok = (n == v);
            4'd11:   ok = (n != v);
            4'd12:   ok = ~z & (n == v);
            4'd13:   ok = z | (n != v);
            4'd14:   ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Only op=00 with a supported command is a legal encoding.
    function automatic logic is_legal(input logic [1:0] op, input logic [3:0] cmd);
        logic ok;
        case (cmd)
            CMD_AND, CMD_XOR, CMD_SUB, CMD_RSB,
            CMD_ADD, CMD_CMP, CMD_OR: ok = 1'b1;
            default:                  ok = 1'b0;
        endcase
        return ok & (op == 2'b00);
    endfunction

`ifdef ALU_CTRL_IMM_ROT_EN
    // imm8 zero-extended, rotated right by twice the 4-bit rotate field.
    function automatic logic [31:0] imm_expand(input logic [11:0] src2);
        logic [63:0] dbl;
        logic [4:0]  sh;
        sh  = {src2[11:8], 1'b0};
        dbl = {32'd0, 24'd0, src2[7:0]};
        dbl = {dbl[31:0], dbl[31:0]} >> sh;
        return dbl[31:0];
    endfunction

    logic [31:0] imm_s;
    assign imm_s = imm_expand(instr[11:0]);
`else
    // imm8 zero-extended; the rotate field has no meaning in this build.
    function automatic logic [31:0] imm_expand(input logic [7:0] imm8);
        return {24'd0, imm8};
    endfunction

    logic [31:0] imm_s;
    logic        imm_rot_unused_s;
    assign imm_s            = imm_expand(instr[7:0]);
    assign imm_rot_unused_s = ^instr[11:8];
`endif

    state_e      state_q,       state_d;
    logic        instr_ready_q, instr_ready_d;
    logic [3:0]  cond_q,        cond_d;
    logic        s_q,           s_d;
    logic [3:0]  rd_q,          rd_d;
    logic        cond_ok_q,     cond_ok_d;
    logic [3:0]  flags_q,       flags_d;
    logic        nzcv_upd_q,    nzcv_upd_d;
    logic [31:0] alu_a_q,       alu_a_d;
    logic [31:0] alu_b_q,       alu_b_d;
    logic [1:0]  alu_op_q,      alu_op_d;
    logic [3:0]  alu_cmd_q,     alu_cmd_d;
    logic        wb_en_q,       wb_en_d;
    logic [3:0]  wb_addr_q,     wb_addr_d;
    logic [31:0] wb_data_q,     wb_data_d;
    logic [3:0]  nzcv_q,        nzcv_d;
    logic        done_q,        done_d;
    logic        illegal_q,     illegal_d;
    logic [31:0] rf_q [RF_DEPTH];
    logic [31:0] rf_d [RF_DEPTH];
    logic        legal_s;

    // Next-state, operand capture, retire decisions and architectural updates.
    always_comb begin
        state_d    = state_q;
        cond_d     = cond_q;
        s_d        = s_q;
        rd_d       = rd_q;
        cond_ok_d  = cond_ok_q;
        flags_d    = flags_q;
        nzcv_upd_d = 1'b0;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        alu_cmd_d  = alu_cmd_q;
        wb_en_d    = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        nzcv_d     = nzcv_q;
        done_d     = 1'b0;
        illegal_d  = 1'b0;
        rf_d       = rf_q;
        legal_s    = is_legal(alu_op_q, alu_cmd_q);

        case (state_q)
            ST_IDLE: begin
                if (instr_valid && instr_ready_q) begin
                    // Operands are fetched at acceptance so the ALU sees them from READ on;
                    // the previous writeback has already landed in rf_q by now.
                    cond_d    = instr[31:28];
                    s_d       = instr[20];
                    rd_d      = instr[15:12];
                    alu_op_d  = instr[27:26];
                    alu_cmd_d = instr[24:21];
                    alu_a_d   = rf_q[instr[19:16]];
                    if (instr[25]) begin
                        alu_b_d = imm_s;
                    end else begin
                        alu_b_d = rf_q[instr[3:0]];
                    end
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                cond_ok_d = cond_pass(cond_q, nzcv_q);
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                flags_d   = alu_flags;
                done_d    = 1'b1;
                illegal_d = ~legal_s;
                state_d   = ST_WB;
                if (legal_s && cond_ok_q) begin
                    if (alu_cmd_q != CMD_CMP) begin
                        wb_en_d   = 1'b1;
                        wb_addr_d = rd_q;
                        wb_data_d = alu_out;
                    end else begin
                        wb_en_d   = 1'b0;
                    end
                    nzcv_upd_d = s_q | (alu_cmd_q == CMD_CMP);
                end else begin
                    nzcv_upd_d = 1'b0;
                end
            end
            ST_WB: begin
                if (wb_en_q) begin
                    rf_d[wb_addr_q] = wb_data_q;
                end else begin
                    rf_d = rf_q;
                end
                if (nzcv_upd_q) begin
                    nzcv_d = flags_q;
                end else begin
                    nzcv_d = nzcv_q;
                end
                // ALU-facing and writeback outputs return to idle values.
                alu_a_d   = 32'd0;
                alu_b_d   = 32'd0;
                alu_op_d  = 2'd0;
                alu_cmd_d = 4'd0;
                wb_addr_d = 4'd0;
                wb_data_d = 32'd0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        instr_ready_d = (state_d == ST_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            instr_ready_q <= 1'b1;
            cond_q        <= 4'd0;
            s_q           <= 1'b0;
            rd_q          <= 4'd0;
            cond_ok_q     <= 1'b0;
            flags_q       <= 4'd0;
            nzcv_upd_q    <= 1'b0;
            alu_a_q       <= 32'd0;
            alu_b_q       <= 32'd0;
            alu_op_q      <= 2'd0;
            alu_cmd_q     <= 4'd0;
            wb_en_q       <= 1'b0;
            wb_addr_q     <= 4'd0;
            wb_data_q     <= 32'd0;
            nzcv_q        <= 4'd0;
            done_q        <= 1'b0;
            illegal_q     <= 1'b0;
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else begin
            state_q       <= state_d;
            instr_ready_q <= instr_ready_d;
            cond_q        <= cond_d;
            s_q           <= s_d;
            rd_q          <= rd_d;
            cond_ok_q     <= cond_ok_d;
            flags_q       <= flags_d;
            nzcv_upd_q    <= nzcv_upd_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            alu_cmd_q     <= alu_cmd_d;
            wb_en_q       <= wb_en_d;
            wb_addr_q     <= wb_addr_d;
            wb_data_q     <= wb_data_d;
            nzcv_q        <= nzcv_d;
            done_q        <= done_d;
            illegal_q     <= illegal_d;
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign instr_ready = instr_ready_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign alu_cmd     = alu_cmd_q;
    assign wb_en       = wb_en_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign nzcv        = nzcv_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed table, reset corner cases and random
// instructions for alu_ctrl_seq. The bench plays the ALU and keeps its own
// architectural model (register array + NZCV) to predict each retirement.
module tb_alu_ctrl_seq;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_op;
    logic [3:0]  alu_cmd;
    logic [31:0] alu_out;
    logic [3:0]  alu_flags;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  nzcv;
    logic        done;
    logic        illegal;

    int checks;
    int failures;

    logic [31:0] rf_m [16];
    logic [3:0]  nzcv_m;

`ifdef ALU_CTRL_IMM_ROT_EN
    localparam logic [31:0] IMM_1FF = 32'hC000_003F;
`else
    localparam logic [31:0] IMM_1FF = 32'h0000_00FF;
`endif

    alu_ctrl_seq dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_cmd     (alu_cmd),
        .alu_out     (alu_out),
        .alu_flags   (alu_flags),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .nzcv        (nzcv),
        .done        (done),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: returns {N,Z,C,V, result}.
    function automatic logic [35:0] alu_ref(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        w = 33'd0;
        case (cmd)
            4'd0:  r = a & b;
            4'd1:  r = a ^ b;
            4'd12: r = a | b;
            4'd4: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd2, 4'd10: begin
                w = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = w[31:0];
                c = w[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd3: begin
                w = {1'b0, b} + {1'b0, ~a} + 33'd1;
                r = w[31:0];
                c = w[32];
                v = (a[31] != b[31]) && (r[31] != b[31]);
            end
            default: r = a + b;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    // The bench is the ALU the controller drives.
    always_comb begin
        {alu_flags, alu_out} = alu_ref(alu_cmd, alu_a, alu_b);
    end

    function automatic logic [31:0] enc(input logic [3:0] cond, input logic [1:0] op, input logic i,
                                        input logic [3:0] cmd, input logic s, input logic [3:0] rn,
                                        input logic [3:0] rd, input logic [11:0] src2);
        return {cond, op, i, cmd, s, rn, rd, src2};
    endfunction

    function automatic logic [31:0] imm_m(input logic [11:0] src2);
        logic [31:0] v;
        v = {24'd0, src2[7:0]};
`ifdef ALU_CTRL_IMM_ROT_EN
        for (int k = 0; k < 2 * int'(src2[11:8]); k++) begin
            v = {v[0], v[31:1]};
        end
`endif
        return v;
    endfunction

    function automatic bit cond_m(input logic [3:0] cond, input logic [3:0] f);
        bit n;
        bit z;
        bit c;
        bit v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return c;
            4'd3:    return !c;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return c && !z;
            4'd9:    return !c || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Issue one instruction from an IDLE negedge and check all four cycles
    // against the model; returns what the DUT produced for table compares.
    task automatic issue(input logic [31:0] ins, input bit noisy,
                         output logic got_wb_en, output logic [3:0] got_addr,
                         output logic [31:0] got_data, output logic [3:0] got_nzcv,
                         output logic got_ill);
        int          n;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [35:0] fr;
        bit          pass;
        bit          legal;
        bit          exp_wb;
        logic [3:0]  exp_nz;
        logic [3:0]  old_nz;
        ea     = rf_m[ins[19:16]];
        eb     = ins[25] ? imm_m(ins[11:0]) : rf_m[ins[3:0]];
        pass   = cond_m(ins[31:28], nzcv_m);
        legal  = (ins[27:26] == 2'b00) && (ins[24:21] inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd10, 4'd12});
        fr     = alu_ref(ins[24:21], ea, eb);
        exp_wb = pass && legal && (ins[24:21] != 4'd10);
        old_nz = nzcv_m;
        exp_nz = (pass && legal && (ins[20] || ins[24:21] == 4'd10)) ? fr[35:32] : nzcv_m;

        n = 0;
        while (instr_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_issue", 32'(instr_ready), 32'd1);
        instr       = ins;
        instr_valid = 1'b1;

        @(negedge clk);  // READ
        if (noisy) begin
            instr = $urandom;
        end else begin
            instr_valid = 1'b0;
            instr       = 32'd0;
        end
        chk("read_ready", 32'(instr_ready), 32'd0);
        chk("read_a", alu_a, ea);
        chk("read_b", alu_b, eb);
        chk("read_op", 32'(alu_op), 32'(ins[27:26]));
        chk("read_cmd", 32'(alu_cmd), 32'(ins[24:21]));
        chk("read_done", 32'(done), 32'd0);

        @(negedge clk);  // EXEC
        if (noisy) instr = $urandom;
        chk("exec_a", alu_a, ea);
        chk("exec_b", alu_b, eb);
        chk("exec_wb_en", 32'(wb_en), 32'd0);
        chk("exec_done", 32'(done), 32'd0);

        @(negedge clk);  // WB
        got_wb_en = wb_en;
        got_addr  = wb_addr;
        got_data  = wb_data;
        got_ill   = illegal;
        chk("wb_wb_en", 32'(wb_en), 32'(exp_wb));
        chk("wb_done", 32'(done), 32'd1);
        chk("wb_illegal", 32'(illegal), 32'(!legal));
        chk("wb_nzcv_old", 32'(nzcv), 32'(old_nz));
        chk("wb_b", alu_b, eb);
        if (exp_wb) begin
            chk("wb_addr", 32'(wb_addr), 32'(ins[15:12]));
            chk("wb_data", wb_data, fr[31:0]);
        end
        instr_valid = 1'b0;
        instr       = 32'd0;

        @(negedge clk);  // back in IDLE
        got_nzcv = nzcv;
        chk("post_ready", 32'(instr_ready), 32'd1);
        chk("post_nzcv", 32'(nzcv), 32'(exp_nz));
        chk("post_done", 32'(done), 32'd0);
        chk("post_wb_en", 32'(wb_en), 32'd0);
        chk("post_alu_a", alu_a, 32'd0);
        chk("post_alu_cmd", 32'(alu_cmd), 32'd0);

        if (exp_wb) rf_m[ins[15:12]] = fr[31:0];
        nzcv_m = exp_nz;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"},   32'(instr_ready), 32'd1);
        chk({tag, "_alu_a"},   alu_a, 32'd0);
        chk({tag, "_alu_b"},   alu_b, 32'd0);
        chk({tag, "_alu_op"},  32'(alu_op), 32'd0);
        chk({tag, "_alu_cmd"}, 32'(alu_cmd), 32'd0);
        chk({tag, "_wb_en"},   32'(wb_en), 32'd0);
        chk({tag, "_wb_addr"}, 32'(wb_addr), 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_nzcv"},    32'(nzcv), 32'd0);
        chk({tag, "_done"},    32'(done), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    endtask

    typedef struct {
        logic [31:0] ins;
        logic        wb_en;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  nzcv;
        logic        ill;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [12];
        logic        g_wb;
        logic [3:0]  g_addr;
        logic [31:0] g_data;
        logic [3:0]  g_nz;
        logic        g_ill;
        logic [3:0]  lc [8];

        // cond, op, I, cmd, S, Rn, Rd, src2 ; expected wb_en, addr, data, nzcv, illegal
        tbl[0]  = '{enc(4'hE, 2'd0, 1'b1, 4'd4,  1'b0, 4'd0, 4'd1,  12'h005), 1'b1, 4'd1,  32'd5,        4'b0000, 1'b0};
        tbl[1]  = '{enc(4'hE, 2'd0, 1'b1, 4'd10, 1'b0, 4'd1, 4'd0,  12'h005), 1'b0, 4'd0,  32'd0,        4'b0110, 1'b0};
        tbl[2]  = '{enc(4'h0, 2'd0, 1'b1, 4'd4,  1'b0, 4'd1, 4'd2,  12'h002), 1'b1, 4'd2,  32'd7,        4'b0110, 1'b0};
        tbl[3]  = '{enc(4'h1, 2'd0, 1'b1, 4'd4,  1'b0, 4'd1, 4'd3,  12'h003), 1'b0, 4'd0,  32'd0,        4'b0110, 1'b0};
        tbl[4]  = '{enc(4'hE, 2'd0, 1'b1, 4'd2,  1'b1, 4'd1, 4'd4,  12'h006), 1'b1, 4'd4,  32'hFFFFFFFF, 4'b1000, 1'b0};
        tbl[5]  = '{enc(4'hE, 2'd0, 1'b1, 4'd7,  1'b1, 4'd1, 4'd5,  12'h001), 1'b0, 4'd0,  32'd0,        4'b1000, 1'b1};
        tbl[6]  = '{enc(4'hE, 2'd1, 1'b1, 4'd4,  1'b1, 4'd1, 4'd5,  12'h001), 1'b0, 4'd0,  32'd0,        4'b1000, 1'b1};
        tbl[7]  = '{enc(4'hE, 2'd0, 1'b1, 4'd4,  1'b0, 4'd0, 4'd6,  12'h1FF), 1'b1, 4'd6,  IMM_1FF,      4'b1000, 1'b0};
        tbl[8]  = '{enc(4'hF, 2'd0, 1'b1, 4'd4,  1'b0, 4'd1, 4'd7,  12'h001), 1'b0, 4'd0,  32'd0,        4'b1000, 1'b0};
        tbl[9]  = '{enc(4'hE, 2'd0, 1'b0, 4'd4,  1'b0, 4'd1, 4'd8,  12'hAB2), 1'b1, 4'd8,  32'd12,       4'b1000, 1'b0};
        tbl[10] = '{enc(4'hE, 2'd0, 1'b1, 4'd4,  1'b0, 4'd5, 4'd9,  12'h000), 1'b1, 4'd9,  32'd0,        4'b1000, 1'b0};
        tbl[11] = '{enc(4'h4, 2'd0, 1'b1, 4'd4,  1'b1, 4'd4, 4'd10, 12'h001), 1'b1, 4'd10, 32'd0,        4'b0110, 1'b0};

        lc[0] = 4'd0; lc[1] = 4'd1; lc[2] = 4'd2; lc[3] = 4'd3;
        lc[4] = 4'd4; lc[5] = 4'd10; lc[6] = 4'd12; lc[7] = 4'd10;

        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        for (int i = 0; i < 16; i++) rf_m[i] = 32'd0;
        nzcv_m = 4'd0;

        repeat (3) @(negedge clk);
        // Offer an instruction while reset is still high: it must not be taken.
        instr       = tbl[0].ins;
        instr_valid = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'd0;
        chk_idle_outputs("reset");
        @(negedge clk);
        chk("reset_hold_ready", 32'(instr_ready), 32'd1);
        chk("reset_hold_done", 32'(done), 32'd0);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            issue(tbl[i].ins, 1'b0, g_wb, g_addr, g_data, g_nz, g_ill);
            chk($sformatf("tbl%0d_wb_en", i), 32'(g_wb), 32'(tbl[i].wb_en));
            if (tbl[i].wb_en) begin
                chk($sformatf("tbl%0d_addr", i), 32'(g_addr), 32'(tbl[i].addr));
                chk($sformatf("tbl%0d_data", i), g_data, tbl[i].data);
            end
            chk($sformatf("tbl%0d_nzcv", i), 32'(g_nz), 32'(tbl[i].nzcv));
            chk($sformatf("tbl%0d_illegal", i), 32'(g_ill), 32'(tbl[i].ill));
        end

        // Reset during EXEC abandons the instruction and clears rf/nzcv.
        instr       = enc(4'hE, 2'd0, 1'b1, 4'd4, 1'b1, 4'd0, 4'd11, 12'h009);
        instr_valid = 1'b1;
        @(negedge clk);  // READ
        instr_valid = 1'b0;
        instr       = 32'd0;
        chk("abort_read_b", alu_b, 32'd9);
        @(negedge clk);  // EXEC
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_outputs("abort");
        @(negedge clk);
        chk("abort_late_done", 32'(done), 32'd0);
        chk("abort_late_wb_en", 32'(wb_en), 32'd0);
        for (int i = 0; i < 16; i++) rf_m[i] = 32'd0;
        nzcv_m = 4'd0;
        // r1 held 5 before the reset; it must read back as 0 now.
        issue(enc(4'hE, 2'd0, 1'b1, 4'd4, 1'b0, 4'd1, 4'd1, 12'h000), 1'b0, g_wb, g_addr, g_data, g_nz, g_ill);
        chk("abort_r1_cleared", g_data, 32'd0);

        // Random instructions back to back, with junk offered while busy.
        for (int t = 0; t < 300; t++) begin
            logic [1:0]  op;
            logic [3:0]  cmd;
            logic [31:0] ins;
            op  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            cmd = ($urandom_range(0, 9) == 0) ? 4'($urandom) : lc[$urandom_range(0, 7)];
            ins = enc(4'($urandom), op, 1'($urandom), cmd, 1'($urandom),
                      4'($urandom), 4'($urandom), 12'($urandom));
            issue(ins, 1'b1, g_wb, g_addr, g_data, g_nz, g_ill);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
